// File: rtl/rng_window_decode.sv
// rng_window_decode: turns a stochastic bitstream back into a binary probability.
// It counts the 1s over a window of 2^iWINLOG2 bits. Each finished window gives a
// ones count, a Q1.(FBITWIDTH-1) probability and a polarity flag, with a one-cycle
// valid pulse. Windows follow one another with no gap cycles.
// Optional feature: define RNG_DECODE_CHECK_EN to add the iProb/oErr tolerance check.
module rng_window_decode #(
  parameter int unsigned BITWIDTH     = 8,
  parameter int unsigned BITWIDTHLOG2 = 3,
  parameter int unsigned FBITWIDTH    = 4
) (
  input  logic                    iClk,
  input  logic                    iRstN,
  input  logic                    iClr,
  input  logic                    iEn,
  input  logic [BITWIDTHLOG2-1:0] iWINLOG2,
  input  logic                    iA,
`ifdef RNG_DECODE_CHECK_EN
  input  logic [FBITWIDTH-1:0]    iProb,
  output logic                    oErr,
`endif
  output logic [BITWIDTH-1:0]     oOnes,
  output logic [FBITWIDTH-1:0]    oProb,
  output logic                    oPolarity,
  output logic                    oValid
);

  localparam int unsigned ProdW = BITWIDTH + FBITWIDTH;

  localparam logic [BITWIDTH-1:0]  CntOne   = {{(BITWIDTH-1){1'b0}}, 1'b1};
  localparam logic [FBITWIDTH-1:0] ProbHalf = {2'b01, {(FBITWIDTH-2){1'b0}}};
  localparam logic [FBITWIDTH-1:0] ProbFull = {1'b1, {(FBITWIDTH-1){1'b0}}};

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e r_state;
  state_e w_state_next;

  logic [BITWIDTH-1:0]     r_cnt_ones;
  logic [BITWIDTH-1:0]     r_cnt_bit;   // bits left in the window after the current one
  logic [BITWIDTHLOG2-1:0] r_win;
  logic [BITWIDTH-1:0]     r_ones;
  logic [FBITWIDTH-1:0]    r_prob;
  logic                    r_pol;
  logic                    r_valid;

  logic                    w_active;
  logic                    w_first;
  logic                    w_last;
  logic                    w_emit;
  logic [BITWIDTHLOG2-1:0] w_win;
  logic [BITWIDTH-1:0]     w_a_ext;
  logic [BITWIDTH-1:0]     w_sum;
  logic [BITWIDTH-1:0]     w_span_m1;
  logic [ProdW-1:0]        w_scaled;
  logic [FBITWIDTH-1:0]    w_prob;
  logic                    w_pol;

  // Clear and a low enable both abort the window in progress; clear wins.
  assign w_active = iEn & ~iClr;

  // The first bit of a window after idle uses the live window size, because
  // nothing has been latched for this window yet.
  assign w_first = (r_state == StIdle);
  assign w_win   = w_first ? iWINLOG2 : r_win;
  assign w_a_ext = {{(BITWIDTH-1){1'b0}}, iA};

  // Running count that includes the bit sampled this cycle.
  assign w_sum     = (w_first ? '0 : r_cnt_ones) + w_a_ext;
  assign w_span_m1 = (CntOne << iWINLOG2) - CntOne;

  // Scale the count to Q1.(FBITWIDTH-1): ones * 2^(FBITWIDTH-1) / 2^win, floored.
  assign w_scaled = ({{FBITWIDTH{1'b0}}, w_sum} << (FBITWIDTH - 1)) >> w_win;
  // The count never exceeds the window length, so the upper bits stay zero.
  // Clamp to full scale anyway so that no scaled bit goes unused.
  assign w_prob   = (|w_scaled[ProdW-1:FBITWIDTH]) ? ProbFull : w_scaled[FBITWIDTH-1:0];
  // Polarity 1 means the stream holds too few 1s (0 inserts needed upstream).
  assign w_pol    = (w_prob < ProbHalf);

  // State register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: any enabled, uncleared cycle runs; otherwise fall back to idle.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  w_state_next = w_active ? StRun : StIdle;
      StRun:   w_state_next = w_active ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: detect the last bit of the window and decide when to report.
  always_comb begin
    w_last = 1'b0;
    unique case (r_state)
      StIdle:  w_last = (iWINLOG2 == '0);
      StRun:   w_last = (r_cnt_bit == '0);
      default: w_last = 1'b0;
    endcase
    w_emit = w_active & w_last;
  end

  // Window counters and result registers.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_cnt_ones <= '0;
      r_cnt_bit  <= '0;
      r_win      <= '0;
      r_ones     <= '0;
      r_prob     <= '0;
      r_pol      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_emit;
      if (!w_active) begin
        // Discard the partial window; the last results stay visible.
        r_cnt_ones <= '0;
        r_cnt_bit  <= '0;
      end else if (w_last) begin
        // Report this window and set up the next one, which starts next cycle.
        r_ones     <= w_sum;
        r_prob     <= w_prob;
        r_pol      <= w_pol;
        r_win      <= iWINLOG2;
        r_cnt_ones <= '0;
        r_cnt_bit  <= w_span_m1;
      end else if (w_first) begin
        // The first bit after idle is already counted, so one fewer remain.
        r_win      <= iWINLOG2;
        r_cnt_ones <= w_sum;
        r_cnt_bit  <= w_span_m1 - CntOne;
      end else begin
        r_cnt_ones <= w_sum;
        r_cnt_bit  <= r_cnt_bit - CntOne;
      end
    end
  end

`ifdef RNG_DECODE_CHECK_EN
  logic [FBITWIDTH-1:0] w_diff;
  logic                 r_err;

  localparam logic [FBITWIDTH-1:0] ProbLsb = {{(FBITWIDTH-1){1'b0}}, 1'b1};

  assign w_diff = (w_prob >= iProb) ? (w_prob - iProb) : (iProb - w_prob);

  // Flag results that are more than one LSB away from the requested probability.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_err <= 1'b0;
    end else if (w_emit) begin
      r_err <= (w_diff > ProbLsb);
    end
  end

  assign oErr = r_err;
`endif

  assign oOnes     = r_ones;
  assign oProb     = r_prob;
  assign oPolarity = r_pol;
  assign oValid    = r_valid;

endmodule

// File: tb/tb_rng_window_decode.sv
// Testbench for rng_window_decode. Stimulus is mostly directed, with one randomized
// phase. Expected values come from a queue-based model of the window.
module tb_rng_window_decode;

  logic       iClk = 1'b0;
  logic       iRstN = 1'b0;
  logic       iClr = 1'b0;
  logic       iEn = 1'b0;
  logic       iA = 1'b0;
  logic [2:0] iWINLOG2 = 3'd0;
  logic [7:0] oOnes;
  logic [3:0] oProb;
  logic       oPolarity;
  logic       oValid;
`ifdef RNG_DECODE_CHECK_EN
  logic [3:0] iProb = 4'd0;
  logic       oErr;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model state: bits of the current window, latched size, last reported result.
  bit m_bits[$];
  bit m_latched;
  int m_win;
  int m_ones;
  int m_prob;
  bit m_pol;
  bit m_valid;
  bit m_err;

  rng_window_decode #(
    .BITWIDTH    (8),
    .BITWIDTHLOG2(3),
    .FBITWIDTH   (4)
  ) dut (
    .iClk     (iClk),
    .iRstN    (iRstN),
    .iClr     (iClr),
    .iEn      (iEn),
    .iWINLOG2 (iWINLOG2),
    .iA       (iA),
`ifdef RNG_DECODE_CHECK_EN
    .iProb    (iProb),
    .oErr     (oErr),
`endif
    .oOnes    (oOnes),
    .oProb    (oProb),
    .oPolarity(oPolarity),
    .oValid   (oValid)
  );

  always #5 iClk = ~iClk;

  task automatic model_reset();
    m_bits.delete();
    m_latched = 1'b0;
    m_win = 0;
    m_ones = 0;
    m_prob = 0;
    m_pol = 1'b0;
    m_valid = 1'b0;
    m_err = 1'b0;
  endtask

  // Advance the model by one clock, using the inputs sampled at that edge.
  task automatic model_step();
    int ones;
    int diff;
    if (!iRstN) begin
      model_reset();
    end else if (iClr || !iEn) begin
      m_bits.delete();
      m_latched = 1'b0;
      m_valid = 1'b0;
    end else begin
      if (!m_latched) begin
        m_win = int'(iWINLOG2);
        m_latched = 1'b1;
      end
      m_bits.push_back(iA);
      if (m_bits.size() == (1 << m_win)) begin
        ones = 0;
        foreach (m_bits[k]) ones += int'(m_bits[k]);
        m_ones = ones;
        m_prob = (ones * 8) / (1 << m_win);
        m_pol = (m_prob < 4);
        m_valid = 1'b1;
`ifdef RNG_DECODE_CHECK_EN
        diff = m_prob - int'(iProb);
        if (diff < 0) diff = -diff;
        m_err = (diff > 1);
`else
        diff = 0;
`endif
        m_bits.delete();
        m_win = int'(iWINLOG2);
        m_latched = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic cycle(input bit en, input bit clr, input bit a, input int win);
    iEn = en;
    iClr = clr;
    iA = a;
    iWINLOG2 = 3'(win);
    @(posedge iClk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    iRstN = 1'b0;
    model_reset();
    repeat (3) @(posedge iClk);
    #1;
    n_checks++;
    if ({oValid, oOnes, oProb, oPolarity} !== 14'd0) begin
      n_errors++;
      $display("FAIL reset: got v=%b ones=%0d prob=%b pol=%b, expected all zero",
               oValid, oOnes, oProb, oPolarity);
    end
    iRstN = 1'b1;
  endtask

  task automatic test_window8();
    bit pat[8] = '{1, 1, 0, 1, 0, 0, 1, 1};
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, pat[i], 3);
      n_checks++;
      if (oValid !== m_valid) begin
        n_errors++;
        $display("FAIL win8 valid bit%0d: got %b expected %b", i, oValid, m_valid);
      end
    end
    n_checks++;
    if ({oValid, oOnes, oProb, oPolarity} !== {1'b1, 8'd5, 4'b0101, 1'b0}) begin
      n_errors++;
      $display("FAIL win8 result: got v=%b ones=%0d prob=%b pol=%b, expected 1/5/0101/0",
               oValid, oOnes, oProb, oPolarity);
    end
    cycle(0, 0, 0, 3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) begin
      cycle(1, 0, (i < 16) ? ((i % 4) == 1) : 1'b1, 4);
      n_checks++;
      if ({oValid, oOnes, oProb, oPolarity} !== {m_valid, 8'(m_ones), 4'(m_prob), m_pol}) begin
        n_errors++;
        $display("FAIL b2b cyc%0d: got v=%b ones=%0d prob=%b pol=%b expected v=%b ones=%0d prob=%0d pol=%b",
                 i, oValid, oOnes, oProb, oPolarity, m_valid, m_ones, m_prob, m_pol);
      end
      if (i == 15) begin
        n_checks++;
        if ({oValid, oOnes, oProb, oPolarity} !== {1'b1, 8'd4, 4'b0010, 1'b1}) begin
          n_errors++;
          $display("FAIL b2b first: got v=%b ones=%0d prob=%b pol=%b, expected 1/4/0010/1",
                   oValid, oOnes, oProb, oPolarity);
        end
      end
    end
    n_checks++;
    if ({oValid, oOnes, oProb, oPolarity} !== {1'b1, 8'd16, 4'b1000, 1'b0}) begin
      n_errors++;
      $display("FAIL b2b second: got v=%b ones=%0d prob=%b pol=%b, expected 1/16/1000/0",
               oValid, oOnes, oProb, oPolarity);
    end
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_win1();
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, (i % 2) == 0, 0);
      n_checks++;
      if ({oValid, oProb} !== {1'b1, ((i % 2) == 0) ? 4'b1000 : 4'b0000}) begin
        n_errors++;
        $display("FAIL win1 cyc%0d: got v=%b prob=%b, expected v=1 prob=%s",
                 i, oValid, oProb, ((i % 2) == 0) ? "1000" : "0000");
      end
    end
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_win128_change();
    bit tail[4] = '{1, 1, 1, 0};
    for (int i = 0; i < 128; i++) begin
      cycle(1, 0, (i % 2) == 0, (i < 50) ? 7 : 2);
      if (i != 127) begin
        n_checks++;
        if (oValid !== 1'b0) begin
          n_errors++;
          $display("FAIL win128 early valid cyc%0d: got %b expected 0", i, oValid);
        end
      end
    end
    n_checks++;
    if ({oValid, oOnes, oProb, oPolarity} !== {1'b1, 8'd64, 4'b0100, 1'b0}) begin
      n_errors++;
      $display("FAIL win128 result: got v=%b ones=%0d prob=%b pol=%b, expected 1/64/0100/0",
               oValid, oOnes, oProb, oPolarity);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, tail[i], 2);
      n_checks++;
      if ({oValid, oOnes, oProb, oPolarity} !== {m_valid, 8'(m_ones), 4'(m_prob), m_pol}) begin
        n_errors++;
        $display("FAIL win4 after change cyc%0d: got v=%b ones=%0d prob=%b expected v=%b ones=%0d prob=%0d",
                 i, oValid, oOnes, oProb, m_valid, m_ones, m_prob);
      end
    end
    n_checks++;
    if ({oValid, oProb} !== {1'b1, 4'b0110}) begin
      n_errors++;
      $display("FAIL win4 result: got v=%b prob=%b, expected 1/0110", oValid, oProb);
    end
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_clear();
    logic [7:0] held_ones;
    logic [3:0] held_prob;
    held_ones = 8'(m_ones);
    held_prob = 4'(m_prob);
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 3);
    cycle(1, 1, 1, 3);
    n_checks++;
    if ({oValid, oOnes, oProb} !== {1'b0, held_ones, held_prob}) begin
      n_errors++;
      $display("FAIL clear hold: got v=%b ones=%0d prob=%b, expected v=0 ones=%0d prob=%b",
               oValid, oOnes, oProb, held_ones, held_prob);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 0, 3);
      n_checks++;
      if (oValid !== m_valid) begin
        n_errors++;
        $display("FAIL clear refill valid bit%0d: got %b expected %b", i, oValid, m_valid);
      end
    end
    n_checks++;
    if ({oValid, oOnes, oProb, oPolarity} !== {1'b1, 8'd0, 4'b0000, 1'b1}) begin
      n_errors++;
      $display("FAIL clear zeros: got v=%b ones=%0d prob=%b pol=%b, expected 1/0/0000/1",
               oValid, oOnes, oProb, oPolarity);
    end
  endtask

  task automatic test_en_drop();
    bit pat[4] = '{1, 0, 1, 1};
    cycle(1, 0, 1, 2);
    cycle(1, 0, 1, 2);
    cycle(0, 0, 1, 2);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, pat[i], 2);
      n_checks++;
      if ({oValid, oOnes, oProb, oPolarity} !== {m_valid, 8'(m_ones), 4'(m_prob), m_pol}) begin
        n_errors++;
        $display("FAIL en drop cyc%0d: got v=%b ones=%0d prob=%b expected v=%b ones=%0d prob=%0d",
                 i, oValid, oOnes, oProb, m_valid, m_ones, m_prob);
      end
    end
    n_checks++;
    if ({oValid, oOnes} !== {1'b1, 8'd3}) begin
      n_errors++;
      $display("FAIL en drop result: got v=%b ones=%0d, expected 1/3", oValid, oOnes);
    end
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 1, 1);
    cycle(1, 0, 1, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 3);
    #2;
    iRstN = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({oValid, oOnes, oProb, oPolarity} !== 14'd0) begin
      n_errors++;
      $display("FAIL reset mid: got v=%b ones=%0d prob=%b pol=%b, expected all zero",
               oValid, oOnes, oProb, oPolarity);
    end
    @(posedge iClk);
    #1;
    iRstN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, i < 6, 3);
      n_checks++;
      if ({oValid, oOnes, oProb, oPolarity} !== {m_valid, 8'(m_ones), 4'(m_prob), m_pol}) begin
        n_errors++;
        $display("FAIL after reset cyc%0d: got v=%b ones=%0d prob=%b expected v=%b ones=%0d prob=%0d",
                 i, oValid, oOnes, oProb, m_valid, m_ones, m_prob);
      end
    end
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit en;
    bit clr;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(99) < 96);
      clr = ($urandom_range(99) < 2);
`ifdef RNG_DECODE_CHECK_EN
      iProb = 4'($urandom_range(8));
`endif
      cycle(en, clr, 1'($urandom), int'($urandom_range(5)));
      n_checks++;
      if ({oValid, oOnes, oProb, oPolarity} !== {m_valid, 8'(m_ones), 4'(m_prob), m_pol}) begin
        n_errors++;
        $display("FAIL random cyc%0d: got v=%b ones=%0d prob=%b pol=%b expected v=%b ones=%0d prob=%0d pol=%b",
                 i, oValid, oOnes, oProb, oPolarity, m_valid, m_ones, m_prob, m_pol);
      end
`ifdef RNG_DECODE_CHECK_EN
      n_checks++;
      if (oErr !== m_err) begin
        n_errors++;
        $display("FAIL random err cyc%0d: got %b expected %b", i, oErr, m_err);
      end
`endif
    end
    cycle(0, 0, 0, 0);
  endtask

`ifdef RNG_DECODE_CHECK_EN
  task automatic test_check();
    iProb = 4'b0110;
    for (int i = 0; i < 8; i++) cycle(1, 0, i < 4, 3);
    n_checks++;
    if ({oValid, oProb, oErr} !== {1'b1, 4'b0100, 1'b1}) begin
      n_errors++;
      $display("FAIL check far: got v=%b prob=%b err=%b, expected 1/0100/1", oValid, oProb, oErr);
    end
    for (int i = 0; i < 8; i++) cycle(1, 0, i < 5, 3);
    n_checks++;
    if ({oValid, oProb, oErr} !== {1'b1, 4'b0101, 1'b0}) begin
      n_errors++;
      $display("FAIL check near: got v=%b prob=%b err=%b, expected 1/0101/0", oValid, oProb, oErr);
    end
    cycle(0, 0, 0, 0);
    n_checks++;
    if (oErr !== 1'b0) begin
      n_errors++;
      $display("FAIL check hold: got err=%b expected 0", oErr);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_window8();
    test_back_to_back();
    test_win1();
    test_win128_change();
    test_clear();
    test_en_drop();
    test_reset_mid();
`ifdef RNG_DECODE_CHECK_EN
    test_check();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
